// File: rtl/rv_ctrl_pkg.sv
// Shared opcode and ALUop definitions for the RV32 control decoders.
// Pure definitions: no latency and no flow control.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic is_stype;
    logic is_rtype;
    logic is_itype;
    logic is_lw;
    logic is_jump;
    logic is_branch;
    logic is_illegal;
  } type_t;

  typedef struct packed {
    type_t      ty;
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/rv_opcode_classify.sv
// Opcode to one-hot instruction-type flags plus illegal flag.
// Combinational, zero latency; no flow control.
module rv_opcode_classify
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output type_t      o_type
);

  always_comb begin
    o_type            = '0;
    o_type.is_stype   = (opcode == OP_STORE);
    o_type.is_rtype   = (opcode == OP_RTYPE);
    o_type.is_itype   = (opcode == OP_ITYPE);
    o_type.is_lw      = (opcode == OP_LOAD);
    o_type.is_jump    = (opcode == OP_JAL);
    o_type.is_branch  = (opcode == OP_BRANCH);
    o_type.is_illegal = ~(o_type.is_stype | o_type.is_rtype | o_type.is_itype |
                          o_type.is_lw | o_type.is_jump | o_type.is_branch);
  end

endmodule

// File: rtl/rv_ctrl_decode.sv
// Main control decoder: opcode -> type flags, datapath strobes and ALUop.
// Latency 0 (REGISTERED=0) or 1 cycle (REGISTERED=1); no backpressure.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit REGISTERED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  output logic       is_stype,
  output logic       is_rtype,
  output logic       is_itype,
  output logic       is_lw,
  output logic       is_jump,
  output logic       is_branch,
  output logic       is_illegal,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem2reg,
  output logic [1:0] alu_op
);

  type_t w_type;
  ctrl_t w_nxt;
  ctrl_t w_out;

  rv_opcode_classify u_classify (
    .opcode (opcode),
    .o_type (w_type)
  );

  always_comb begin
    w_nxt           = '0;
    w_nxt.ty        = w_type;
    w_nxt.reg_write = w_type.is_rtype | w_type.is_itype | w_type.is_lw | w_type.is_jump;
    w_nxt.alu_src   = w_type.is_itype | w_type.is_lw | w_type.is_stype;
    w_nxt.mem_read  = w_type.is_lw;
    w_nxt.mem_write = w_type.is_stype;
    w_nxt.mem2reg   = w_type.is_lw;
    // Illegal opcodes set neither bit, so alu_op falls back to ADD.
    w_nxt.alu_op    = {w_type.is_rtype, w_type.is_branch};
  end

  generate
    if (REGISTERED) begin : g_reg
      ctrl_t r_q;

      // Reset clears is_illegal too, so a held-in-reset stage reads as a bubble.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else begin
          r_q <= w_nxt;
        end
      end

      assign w_out = r_q;
    end else begin : g_comb
      logic w_unused;
      assign w_unused = clk | rst_n;
      assign w_out    = w_nxt;
    end
  endgenerate

  assign is_stype   = w_out.ty.is_stype;
  assign is_rtype   = w_out.ty.is_rtype;
  assign is_itype   = w_out.ty.is_itype;
  assign is_lw      = w_out.ty.is_lw;
  assign is_jump    = w_out.ty.is_jump;
  assign is_branch  = w_out.ty.is_branch;
  assign is_illegal = w_out.ty.is_illegal;
  assign reg_write  = w_out.reg_write;
  assign alu_src    = w_out.alu_src;
  assign mem_read   = w_out.mem_read;
  assign mem_write  = w_out.mem_write;
  assign mem2reg    = w_out.mem2reg;
  assign alu_op     = w_out.alu_op;

endmodule

// File: tb/tb_rv_ctrl_decode.sv
// Bench for rv_ctrl_decode: combinational and registered instances share one opcode stream.
module tb_rv_ctrl_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = 7'b0000011;

  // Vector order: stype rtype itype lw jump branch illegal | reg_write alu_src mem_read mem_write mem2reg | alu_op
  logic [13:0] c_vec, r_vec;
  logic [13:0] exp_r = '0;
  int n_chk = 0;
  int n_err = 0;

  logic c_st, c_rt, c_it, c_lw, c_j, c_br, c_il, c_rw, c_as, c_mr, c_mw, c_m2r;
  logic [1:0] c_ao;
  logic r_st, r_rt, r_it, r_lw, r_j, r_br, r_il, r_rw, r_as, r_mr, r_mw, r_m2r;
  logic [1:0] r_ao;

  localparam logic [13:0] V_R   = 14'b01000001000010;
  localparam logic [13:0] V_LW  = 14'b00010001110100;
  localparam logic [13:0] V_SW  = 14'b10000000101000;
  localparam logic [13:0] V_BR  = 14'b00000100000001;
  localparam logic [13:0] V_JAL = 14'b00001001000000;
  localparam logic [13:0] V_I   = 14'b00100001100000;
  localparam logic [13:0] V_ILL = 14'b00000010000000;

  rv_ctrl_decode #(.REGISTERED(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .is_stype(c_st), .is_rtype(c_rt), .is_itype(c_it), .is_lw(c_lw),
    .is_jump(c_j), .is_branch(c_br), .is_illegal(c_il),
    .reg_write(c_rw), .alu_src(c_as), .mem_read(c_mr), .mem_write(c_mw),
    .mem2reg(c_m2r), .alu_op(c_ao)
  );

  rv_ctrl_decode #(.REGISTERED(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .is_stype(r_st), .is_rtype(r_rt), .is_itype(r_it), .is_lw(r_lw),
    .is_jump(r_j), .is_branch(r_br), .is_illegal(r_il),
    .reg_write(r_rw), .alu_src(r_as), .mem_read(r_mr), .mem_write(r_mw),
    .mem2reg(r_m2r), .alu_op(r_ao)
  );

  assign c_vec = {c_st, c_rt, c_it, c_lw, c_j, c_br, c_il, c_rw, c_as, c_mr, c_mw, c_m2r, c_ao};
  assign r_vec = {r_st, r_rt, r_it, r_lw, r_j, r_br, r_il, r_rw, r_as, r_mr, r_mw, r_m2r, r_ao};

  always #5 clk = ~clk;

  // Reference: one row per instruction class, straight from the instruction semantics.
  function automatic logic [13:0] model(input logic [6:0] op);
    case (op)
      7'b0110011: model = V_R;
      7'b0000011: model = V_LW;
      7'b0100011: model = V_SW;
      7'b1100011: model = V_BR;
      7'b1101111: model = V_JAL;
      7'b0010011: model = V_I;
      default:    model = V_ILL;
    endcase
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: opcode=%b got %b expected %b at %0t", name, opcode, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_r <= '0;
    else        exp_r <= model(opcode);
  end

  always @(negedge clk) begin
    chk("comb_model", c_vec, model(opcode));
    chk("reg_model", r_vec, exp_r);
  end

  function automatic logic [6:0] rand_op();
    logic [6:0] legal [6];
    legal = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0010011};
    case ($urandom_range(0, 3))
      0, 1:    rand_op = legal[$urandom_range(0, 5)];
      2:       rand_op = 7'b1100111;
      default: rand_op = 7'($urandom);
    endcase
  endfunction

  initial begin
    logic [6:0] ops [7];
    logic [13:0] exps [7];
    ops  = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0010011, 7'b1111111};
    exps = '{V_R, V_LW, V_SW, V_BR, V_JAL, V_I, V_ILL};

    #1 rst_n = 1'b0;
    opcode = 7'b0000011;
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", r_vec, 14'b0);

    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("first_capture_lw", r_vec, V_LW);
    chk("first_capture_mem_read", {13'b0, r_mr}, 14'd1);
    #2 opcode = 7'b0100011;
    #1 chk("hold_between_edges", r_vec, V_LW);
    chk("comb_sw_immediate", c_vec, V_SW);
    @(posedge clk);
    #1 chk("capture_sw", r_vec, V_SW);

    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2 opcode = rand_op();
    end

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_cycle_reset", r_vec, 14'b0);
    repeat (2) @(posedge clk);
    #1 chk("reset_held_clocks", r_vec, 14'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2 opcode = rand_op();
    end

    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #2 opcode = ops[i];
      #1 chk("comb_literal", c_vec, exps[i]);
      @(posedge clk);
      #1 chk("reg_literal", r_vec, exps[i]);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_ctrl_decode.md
Name: rv_ctrl_decode

Overview:
- Main control decoder for the single-cycle RV32 datapath.
- Classifies the 7-bit opcode (ins[6:0]) into instruction-type flags, which is the C1 function.
- Derives the datapath control strobes (C2) and the 2-bit ALUop (C3).
- ALUop feeds the ALU-function decoder downstream, which combines it with funct3.
- An optional output register stage lets the block serve a pipelined datapath.

Parameters:
- REGISTERED, 0, 0 = outputs are purely combinational from opcode; 1 = outputs are registered on the rising edge of clk.

Ports:
- clk  input  1  system clock; used only when REGISTERED=1.
- rst_n  input  1  reset, asynchronous and active-low; used only when REGISTERED=1.
- opcode  input  7  instruction bits [6:0].
- is_stype  output  1  store, opcode 0100011.
- is_rtype  output  1  register ALU op, opcode 0110011.
- is_itype  output  1  immediate ALU op, opcode 0010011.
- is_lw  output  1  load, opcode 0000011.
- is_jump  output  1  JAL, opcode 1101111.
- is_branch  output  1  conditional branch, opcode 1100011.
- is_illegal  output  1  opcode matches none of the six encodings above.
- reg_write  output  1  register-file write enable.
- alu_src  output  1  1 = ALU operand B is the immediate; 0 = operand B is rd2.
- mem_read  output  1  data-memory read enable.
- mem_write  output  1  data-memory write enable.
- mem2reg  output  1  1 = write-back data comes from memory; 0 = it comes from the ALU.
- alu_op  output  2  ALU operation class.

Behaviour:
- Type decode:
  - Exact 7-bit equality compare against each opcode listed in Ports.
  - At most one type flag is high.
  - is_illegal = NOR of the six type flags.
- Control equations:
  - reg_write = is_rtype | is_itype | is_lw | is_jump
  - alu_src = is_itype | is_lw | is_stype
  - mem_read = is_lw
  - mem_write = is_stype
  - mem2reg = is_lw
- ALU op class:
  - alu_op = {is_rtype, is_branch}
  - 00 = add (address/immediate/jump); 01 = subtract (branch compare); 10 = function selected by funct3 downstream; 11 = never produced.
- Illegal opcode: every control output is 0 (no register write, no memory access, alu_op 00) and is_illegal = 1.
- JALR (1100111), LUI, AUIPC and SYSTEM are treated as illegal in this revision.
- REGISTERED=0:
  - Zero latency, no internal state; clk and rst_n are ignored.
  - Outputs settle within the same delta as opcode.
- REGISTERED=1:
  - One-cycle latency: all outputs are captured together on posedge clk from the current opcode.
  - rst_n low asynchronously forces every output to 0, is_illegal included.
  - Deassertion is synchronized externally; the first capture happens on the first posedge with rst_n high.
  - Reset asserted mid-operation clears the outputs immediately, regardless of clk.
- No X propagation: an opcode containing X/Z is outside scope, but the decode still uses full compares, not casez wildcards.

Decomposition:
- Shared package rv_ctrl_pkg:
  - localparams for the six opcodes (OP_STORE, OP_RTYPE, OP_ITYPE, OP_LOAD, OP_JAL, OP_BRANCH).
  - ALUop codes ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10.
  - Reused by the ALU-function decoder.
- One natural sub-module: rv_opcode_classify (opcode -> six flags + is_illegal).
- The control equations and the optional register stage live in the top-level module.

Test Plan:
- opcode 0110011 (add x3,x1,x2), REGISTERED=0 -> is_rtype=1, reg_write=1, alu_src=0, mem_read=0, mem_write=0, mem2reg=0, alu_op=10.
- opcode 0000011 (lw) -> is_lw=1, reg_write=1, alu_src=1, mem_read=1, mem2reg=1, mem_write=0, alu_op=00.
- opcode 0100011 (sw) -> is_stype=1, alu_src=1, mem_write=1, reg_write=0, mem_read=0, alu_op=00.
- opcode 1100011 (beq) -> is_branch=1, alu_op=01, reg_write=0, alu_src=0, all memory strobes 0.
- opcode 1101111 (jal) -> is_jump=1, reg_write=1, alu_op=00; opcode 0010011 -> is_itype=1, reg_write=1, alu_src=1; opcode 1111111 -> is_illegal=1 and every other output 0.
- REGISTERED=1:
  - Hold rst_n=0 with opcode=lw -> all outputs 0.
  - Release rst_n, then on the next posedge -> mem_read=1.
  - Change opcode to sw between edges -> outputs stay unchanged until the following posedge.
  - Drop rst_n mid-cycle -> all outputs 0 immediately.
